// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_pkg;

  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_HALT
  } if_state_t;

  // Where a redirect sends the FSM: any request the memory has already taken
  // must still be drained through S_DROP before the new target is fetched.
  function automatic if_state_t redirect_next(input if_state_t s,
                                              input logic      ready,
                                              input logic      rvalid);
    if_state_t n;
    case (s)
      S_REQ:          n = ready  ? S_DROP : S_REQ;
      S_WAIT, S_DROP: n = rvalid ? S_REQ  : S_DROP;
      S_HALT:         n = S_HALT;
      default:        n = S_REQ;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, one outstanding imem request, valid/ready to decode.
// Optional IF_MISALIGN_CHK_EN: misaligned redirect target halts fetch and raises if_misalign.
module instruction_fetch
  import if_pkg::*;
#(
  parameter logic [ILEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [ILEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [ILEN-1:0] Instruction,
  output logic [ILEN-1:0] if_pc,
  output logic [ILEN-1:0] if_pc4,
  input  logic            redirect,
  input  logic [ILEN-1:0] redirect_pc,
  output logic            if_misalign
);

  if_state_t       state_q;
  logic [ILEN-1:0] pc_q;
  logic [ILEN-1:0] instr_q;
  logic [ILEN-1:0] if_pc_q;
  logic [ILEN-1:0] tgt_pc;

  assign tgt_pc = redirect_pc & ~32'd3;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_q;
  assign if_misalign = misalign_q;
`else
  assign if_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      if_pc_q <= RESET_PC;
`ifdef IF_MISALIGN_CHK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ:  if (imem_ready) state_q <= S_WAIT;
        S_WAIT: begin
          if (imem_rvalid && !redirect) begin
            instr_q <= imem_rdata;
            if_pc_q <= pc_q;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            pc_q    <= pc_q + 32'd4;
            state_q <= S_REQ;
          end
        end
        S_DROP:  if (imem_rvalid) state_q <= S_REQ;
        default: state_q <= state_q;
      endcase

      // Redirect overrides the normal transition; a same-cycle transfer in
      // S_HOLD has already completed, so only the PC increment is replaced.
      if (redirect && state_q != S_HALT) begin
`ifdef IF_MISALIGN_CHK_EN
        if (|redirect_pc[1:0]) begin
          misalign_q <= 1'b1;
          state_q    <= S_HALT;
        end else
`endif
        begin
          pc_q    <= tgt_pc;
          state_q <= redirect_next(state_q, imem_ready, imem_rvalid);
        end
      end
    end
  end

  always_comb begin
    imem_req    = (state_q == S_REQ);
    if_valid    = (state_q == S_HOLD);
    imem_addr   = pc_q;
    if_pc       = if_pc_q;
    if_pc4      = if_pc_q + 32'd4;
    Instruction = (state_q == S_HOLD) ? instr_q : NOP_INSTR;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: PC/memory reference model plus directed scenarios.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] Instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_misalign;

  instruction_fetch #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .Instruction (Instruction),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_misalign (if_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          rdy_pct, ifr_pct, lat_min, lat_max;
  logic [31:0] model_pc;
  bit          halted;
  logic [31:0] pend_addr[$];
  int          pend_wait[$];
  logic [31:0] xfer[$];
  bit          obs_req, obs_valid;
  bit          found;
  logic [31:0] snap_instr, snap_pc;

  // Memory contents: a fixed scramble of the address, never equal to the NOP.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reset_check();
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_valid", {31'd0, if_valid},    32'd0);
    chk("rst_instr", Instruction,          32'h13);
    chk("rst_pc",    if_pc,                32'd0);
    chk("rst_pc4",   if_pc4,               32'd4);
    chk("rst_addr",  imem_addr,            32'd0);
    chk("rst_mis",   {31'd0, if_misalign}, 32'd0);
  endtask

  // One clock: check outputs against the model, then drive memory/decode/redirect.
  // rmode: 0 = no redirect, 1 = redirect, 2 = redirect only when a request is up (forced accept).
  task automatic cycle(input int rmode, input logic [31:0] rt);
    bit do_rd;
    @(negedge clk);
    obs_req   = imem_req;
    obs_valid = if_valid;
    if (halted) begin
      chk("halt_req",   {31'd0, imem_req},    32'd0);
      chk("halt_valid", {31'd0, if_valid},    32'd0);
      chk("halt_mis",   {31'd0, if_misalign}, 32'd1);
    end else begin
      chk("misalign", {31'd0, if_misalign}, 32'd0);
      if (imem_req) begin
        chk("req_addr", imem_addr, model_pc);
        chk("one_outstanding", pend_addr.size(), 32'd0);
        chk("req_not_valid", {31'd0, if_valid}, 32'd0);
      end
      if (if_valid) begin
        chk("if_pc",  if_pc,       model_pc);
        chk("instr",  Instruction, memf(model_pc));
        chk("if_pc4", if_pc4,      model_pc + 32'd4);
      end else begin
        chk("nop_instr", Instruction, 32'h13);
      end
    end

    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend_addr.size() > 0) begin
      if (pend_wait[0] == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_wait.pop_front());
      end else begin
        pend_wait[0] = pend_wait[0] - 1;
      end
    end

    do_rd = (rmode == 1) || (rmode == 2 && obs_req);
    imem_ready = ($urandom_range(0, 99) < rdy_pct) || (rmode == 2 && obs_req);
    if (obs_req && imem_ready) begin
      pend_addr.push_back(imem_addr);
      pend_wait.push_back($urandom_range(lat_min, lat_max));
    end

    if_ready = ($urandom_range(0, 99) < ifr_pct);
    if (obs_valid && if_ready && !halted) begin
      xfer.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end

    redirect    = do_rd;
    redirect_pc = do_rd ? rt : $urandom;
    if (do_rd && !halted) begin
`ifdef IF_MISALIGN_CHK_EN
      if (rt[1:0] != 2'b00) halted = 1'b1;
      else model_pc = rt;
`else
      model_pc = rt & ~32'd3;
`endif
    end
  endtask

  task automatic run_until_req(input string tag);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(0, 32'd0);
      if (obs_req) found = 1'b1;
    end
    if (!found) chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    if_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rdy_pct = 100; ifr_pct = 100; lat_min = 0; lat_max = 0;
    model_pc = 32'd0; halted = 1'b0;
    repeat (2) @(negedge clk);
    reset_check();
    reset = 1'b1;

    // 1: in-order fetch with a 1-cycle memory, first valid 3 cycles after release
    found = 1'b0;
    for (int k = 1; k <= 10 && !found; k++) begin
      cycle(0, 32'd0);
      if (obs_valid) begin
        found = 1'b1;
        chk("first_valid_latency", k, 32'd3);
      end
    end
    if (!found) chk("first_valid_timeout", 32'd0, 32'd1);
    for (int k = 0; k < 30 && xfer.size() < 3; k++) cycle(0, 32'd0);
    if (xfer.size() >= 3) begin
      chk("order0", xfer[0], 32'h0);
      chk("order1", xfer[1], 32'h4);
      chk("order2", xfer[2], 32'h8);
    end else chk("order_timeout", xfer.size(), 32'd3);

    // 2: decode stalls for 5 cycles
    ifr_pct = 0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle(0, 32'd0);
      if (obs_valid) found = 1'b1;
    end
    if (!found) chk("hold_timeout", 32'd0, 32'd1);
    snap_instr = Instruction;
    snap_pc    = if_pc;
    for (int k = 0; k < 5; k++) begin
      cycle(0, 32'd0);
      chk("hold_valid", {31'd0, obs_valid}, 32'd1);
      chk("hold_req",   {31'd0, obs_req},   32'd0);
      chk("hold_instr", Instruction, snap_instr);
      chk("hold_pc",    if_pc,       snap_pc);
    end
    ifr_pct = 100;

    // 3: redirect while waiting, stale word arrives 2 cycles later
    lat_min = 2; lat_max = 2;
    run_until_req("t3_req_timeout");
    cycle(1, 32'h100);
    chk("t3_in_wait", {30'd0, obs_req, obs_valid}, 32'd0);
    xfer.delete();
    run_until_req("t3_req2_timeout");
    chk("t3_addr", imem_addr, 32'h100);
    for (int k = 0; k < 20 && xfer.size() < 1; k++) cycle(0, 32'd0);
    chk("t3_first_xfer", (xfer.size() > 0) ? xfer[0] : 32'hDEAD_BEEF, 32'h100);

    // 4: redirect in the same cycle the memory accepts
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(2, 32'h200);
      if (obs_req) found = 1'b1;
    end
    if (!found) chk("t4_timeout", 32'd0, 32'd1);
    run_until_req("t4_req_timeout");
    chk("t4_addr", imem_addr, 32'h200);

    // 5: asynchronous reset while waiting on memory
    lat_min = 3; lat_max = 3;
    run_until_req("t5_req_timeout");
    cycle(0, 32'd0);
    #2 reset = 1'b0;
    #1 reset_check();
    pend_addr.delete(); pend_wait.delete(); xfer.delete();
    model_pc = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    imem_rvalid = 1'b0; redirect = 1'b0;

    // random traffic with aligned redirects
    rdy_pct = 60; ifr_pct = 60; lat_min = 0; lat_max = 3;
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 99) < 4) cycle(1, $urandom & 32'hFFFF_FFFC);
      else cycle(0, 32'd0);
    end

    // PC wraps at 2^32
    rdy_pct = 100; ifr_pct = 100;
    cycle(1, 32'hFFFF_FFF8);
    xfer.delete();
    for (int k = 0; k < 60 && xfer.size() < 3; k++) cycle(0, 32'd0);
    chk("wrap_xfer", (xfer.size() > 2) ? xfer[2] : 32'hDEAD_BEEF, 32'h0);

    // 6: misaligned redirect target
    cycle(1, 32'h102);
`ifdef IF_MISALIGN_CHK_EN
    for (int k = 0; k < 10; k++) cycle(0, 32'd0);
    chk("t6_misalign", {31'd0, if_misalign}, 32'd1);
`else
    run_until_req("t6_req_timeout");
    chk("t6_addr", imem_addr, 32'h100);
    for (int k = 0; k < 10; k++) cycle(0, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
